// File: rtl/serial_pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx_pkg
// Shared definitions for the serial pattern transmitter:
//   - state_e      : 2-bit FSM state encoding (IDLE, SHIFT, DONE, PARITY)
//   - DEF_PAT_W    : default pattern width
//   - DEF_CNT_W    : default repeat-count width
//   - DEF_PATTERN  : default test pattern (3'b110)
// -----------------------------------------------------------------------------
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    DONE   = 2'b10,
    PARITY = 2'b11
  } state_e;

  localparam int DEF_PAT_W = 3;
  localparam int DEF_CNT_W = 4;

  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b110;

endpackage

// File: rtl/serial_pattern_tx_shifter.sv
// -----------------------------------------------------------------------------
// pattern_shifter
// W-bit loadable left-shift register paired with a bit down-counter.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-low reset (clears register and counter)
//   load  : load din into the register, counter set to W-1 (wins over shift)
//   shift : shift left by one and decrement, only while the counter is nonzero
//   din   : parallel load value
//   msb   : current register MSB (the bit being transmitted)
//   last  : counter has reached zero (current MSB is the last bit of the copy)
// -----------------------------------------------------------------------------
module pattern_shifter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      shreg_d   = din;
      bit_cnt_d = CW'(W - 1);
    end else if (shift && (bit_cnt_q != '0)) begin
      shreg_d   = {shreg_q[W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign msb  = shreg_q[W-1];
  assign last = (bit_cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
// Captures a PAT_W-bit pattern on start and shifts it out MSB-first, one bit
// per clock, repeated max(repeat_n,1) times back to back, then pulses done.
// Outputs are decoded from registered state only (Moore).
//
// Optional build macro: SERIAL_PATTERN_TX_PARITY_EN
//   When defined, each pattern copy is followed by one even-parity bit
//   (XOR of the captured pattern), emitted with valid=1 and busy=1.
//
// Ports:
//   clk         : clock
//   reset       : synchronous active-low reset
//   start       : burst request, sampled only in IDLE
//   pattern     : bits to send, MSB first, captured on start acceptance
//   repeat_n    : number of copies (0 behaves as 1)
//   out         : serial data bit (IDLE_LVL when not transmitting)
//   valid       : out carries a pattern (or parity) bit
//   busy        : burst in progress
//   done        : one-cycle pulse after the last data bit
//   dbg_state_o : current FSM state
//
// Handshake: start is a level request; it is accepted on the posedge where
// the FSM is in IDLE and start=1. There is no backpressure; requests while
// busy or in DONE are dropped, not queued.
// -----------------------------------------------------------------------------
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int   PAT_W    = DEF_PAT_W,
  parameter int   CNT_W    = DEF_CNT_W,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [PAT_W-1:0] pat_copy_q, pat_copy_d;

  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_msb;
  logic             sh_last;

  pattern_shifter #(
    .W (PAT_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb),
    .last  (sh_last)
  );

  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    pat_copy_d = pat_copy_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_din     = pat_copy_q;
    out        = IDLE_LVL;
    valid      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_load    = 1'b1;
          sh_din     = pattern;
          pat_copy_d = pattern;
          rep_cnt_d  = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        out   = sh_msb;
        valid = 1'b1;
        busy  = 1'b1;
        if (!sh_last) begin
          sh_shift = 1'b1;
        end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_d = PARITY;
`else
          // Reload immediately so the next copy follows with no gap.
          // rep_cnt only decrements while >1, so full scale never wraps.
          if (rep_cnt_q > CNT_W'(1)) begin
            sh_load   = 1'b1;
            rep_cnt_d = rep_cnt_q - CNT_W'(1);
          end else begin
            state_d = DONE;
          end
`endif
        end
      end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PARITY: begin
        out   = ^pat_copy_q;
        valid = 1'b1;
        busy  = 1'b1;
        if (rep_cnt_q > CNT_W'(1)) begin
          sh_load   = 1'b1;
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          state_d   = SHIFT;
        end else begin
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rep_cnt_q  <= '0;
      pat_copy_q <= '0;
    end else begin
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      pat_copy_q <= pat_copy_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial pattern transmitter: the sending end of the single-bit `in` stream consumed by the team's Moore sequence detectors.
- Captures a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeated a programmable number of times.
- Signals the end of the burst with a one-cycle done pulse.
- Drives detector testbenches and on-chip stimulus paths. Its `out` connects directly to a detector's `in`.

Parameters:
- PAT_W, 3, pattern width in bits (min 2).
- CNT_W, 4, width of repeat count.
- IDLE_LVL, 1'b0, level driven on `out` when not transmitting.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- start  input  1  request to begin a burst; sampled only in IDLE
- pattern  input  PAT_W  bits to send, MSB first; captured when start is accepted
- repeat_n  input  CNT_W  number of pattern copies; 0 treated as 1
- out  output  1  serial data bit
- valid  output  1  high on cycles where `out` carries a pattern or parity bit
- busy  output  1  high from the cycle after start acceptance through the last data bit
- done  output  1  one-cycle pulse after the last data bit

Behaviour:
- Reset (reset==0 at posedge), overriding all else:
  - state=IDLE; out=IDLE_LVL; valid=0, busy=0, done=0.
  - Shift register, pattern copy, bit counter and repeat counter all cleared.
  - Reset mid-burst aborts it immediately; no done pulse.
- Moore outputs: out/valid/busy/done depend on registered state and the shift register only, never combinationally on start/pattern.
- States:
  - IDLE:
    - out=IDLE_LVL, valid=0, busy=0.
    - On start=1: capture pattern into shreg and pat_copy; rep_cnt=max(repeat_n,1); bit_cnt=PAT_W-1; next=SHIFT.
  - SHIFT:
    - out=shreg[PAT_W-1], valid=1, busy=1.
    - Each cycle, if bit_cnt!=0: shift shreg left by 1, bit_cnt--.
    - If bit_cnt==0 and rep_cnt>1: shreg=pat_copy, bit_cnt=PAT_W-1, rep_cnt--, stay in SHIFT (back-to-back copies, no gap).
    - If bit_cnt==0 and rep_cnt==1: next=DONE.
  - DONE:
    - done=1, valid=0, busy=0, out=IDLE_LVL.
    - Next=IDLE unconditionally; start is ignored in DONE.
- Latency: first data bit appears on out the cycle after the posedge that samples start=1.
- Burst length: exactly PAT_W*max(repeat_n,1) valid cycles.
- Done timing: done is asserted on the cycle after the last valid bit.
- Minimum start-to-start spacing: burst length + 2 cycles.
- start while busy or in DONE: ignored. No queuing, no restart.
- Changes on pattern/repeat_n after capture: no effect on the current burst.
- repeat_n at full scale (2^CNT_W-1) must not wrap: rep_cnt is CNT_W bits and only decrements down to 1.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - After each pattern copy, a PARITY state emits one bit = XOR of pat_copy (even parity), with valid=1 and busy=1.
  - It then reloads for the next copy or goes to DONE.
  - Burst = (PAT_W+1)*reps valid cycles.
- Undefined: PARITY state and its logic are absent; behaviour is exactly as above.

Decomposition:
- Package serial_pattern_tx_pkg holds:
  - state encoding localparams: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10, PARITY=2'b11, 2-bit state;
  - default PAT_W/CNT_W;
  - the default test pattern 3'b110.
- One natural sub-module, pattern_shifter:
  - PAT_W-bit loadable left-shift register with a down-counter;
  - ports load, shift, din, msb, last.
- The FSM and counters for repeats stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-burst (pattern 3'b110, repeat_n=4) -> next cycle out=0, valid=0, busy=0; no done pulse ever follows.
- Single burst: start=1 for one cycle with pattern=3'b110, repeat_n=1 -> out=1,1,0 with valid=1 on cycles 1-3, done=1 on cycle 4, busy=0 on cycle 4. A detector fed by out asserts its output after bit 3.
- Repeats: pattern=3'b101, repeat_n=3 -> 9 contiguous valid bits 101101101, single done pulse.
- repeat_n=0 -> behaves as 1: 3 valid bits, then done.
- Ignored requests:
  - start held high through the whole burst, pattern changed to 3'b011 mid-burst -> original bits sent.
  - A new burst begins only from IDLE: start sampled in IDLE, i.e. the cycle after done.
- With SERIAL_PATTERN_TX_PARITY_EN: pattern=3'b110, repeat_n=2 -> 1,1,0,0,1,1,0,0 with valid=1 for 8 cycles, then done.
